// File: rtl/task_op_dispatcher.sv
// Issuing end of the per-task op bus: queues host commands in a FIFO, serialises them as 16-bit
// op words, and interleaves slice-driven Execute/Finish pairs for the sorter's winning task.
module task_op_dispatcher #(
  parameter int FIFO_DEPTH   = 4,
  parameter int HOLD_CYCLES  = 1,
  parameter int SLICE_CYCLES = 10000,
  parameter int RUN_CYCLES   = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_id,
  input  logic [3:0]  cmd_code,
  input  logic [3:0]  cmd_arg,
  input  logic        sched_en,
  input  logic        winner_valid,
  input  logic [3:0]  winner_id,
  output logic [15:0] out_op,
  output logic        busy,
  output logic [3:0]  cur_task,
  output logic        cmd_err
);

  typedef struct packed {
    logic [3:0] id;
    logic [3:0] code;
    logic [3:0] arg;
  } cmd_t;

  typedef enum logic [2:0] {S_IDLE, S_HOST, S_EXEC, S_RUN, S_FIN, S_GAP} state_e;

  localparam logic [3:0] OP_EXECUTE = 4'b0111;
  localparam logic [3:0] OP_FINISH  = 4'b1111;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_FW  = PTR_W + 1;
  localparam int TMR_MAX = (HOLD_CYCLES > RUN_CYCLES) ? HOLD_CYCLES : RUN_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int SLC_W   = $clog2(SLICE_CYCLES);

  function automatic logic is_legal(input logic [3:0] code);
    case (code)
      4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b1100: is_legal = 1'b1;
      default:                                                         is_legal = 1'b0;
    endcase
  endfunction

  cmd_t              fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_FW-1:0] fifo_cnt;
  logic              full, empty, accept, push, pop, take;
  logic [SLC_W-1:0]  slice_cnt;
  logic              slice_wrap, slice_pend;
  state_e            state, state_d;
  logic [TMR_W-1:0]  tmr;
  logic              hold_done, run_done;
  logic [15:0]       out_op_d;

  assign full      = (fifo_cnt == CNT_FW'(FIFO_DEPTH));
  assign empty     = (fifo_cnt == '0);
  assign cmd_ready = RST_N && !full;
  assign accept    = cmd_valid && cmd_ready;
  assign push      = accept && is_legal(cmd_code);

  // Slice-driven Execute wins the IDLE decision over queued host commands.
  assign take = (state == S_IDLE) && slice_pend && sched_en && winner_valid;
  assign pop  = (state == S_IDLE) && !take && !empty;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      cmd_err  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (pop && !push) fifo_cnt <= fifo_cnt - 1'b1;
      if (accept && !is_legal(cmd_code)) cmd_err <= 1'b1;
    end
  end

  // NOTE: FIFO storage has no reset; fifo_cnt alone decides which entries are valid.
  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr] <= '{id: cmd_id, code: cmd_code, arg: cmd_arg};
  end

  assign slice_wrap = (slice_cnt == SLC_W'(SLICE_CYCLES - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      slice_cnt  <= '0;
      slice_pend <= 1'b0;
    end else begin
      slice_cnt <= slice_wrap ? '0 : slice_cnt + 1'b1;
      if (!sched_en || take)  slice_pend <= 1'b0;
      else if (slice_wrap)    slice_pend <= 1'b1;
    end
  end

  assign hold_done = (tmr == TMR_W'(HOLD_CYCLES - 1));
  assign run_done  = (tmr == TMR_W'(RUN_CYCLES - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_IDLE;
      tmr   <= '0;
    end else begin
      state <= state_d;
      tmr   <= (state_d != state) ? '0 : tmr + 1'b1;
    end
  end

  always_comb begin
    // NOTE: state_d defaults to state so no path leaves it unassigned and no latch is inferred.
    state_d = state;
    unique case (state)
      S_IDLE: if (take) state_d = S_EXEC;
              else if (pop) state_d = S_HOST;
      S_HOST: if (hold_done) state_d = S_GAP;
      S_EXEC: if (hold_done) state_d = S_RUN;
      S_RUN:  if (run_done)  state_d = S_FIN;
      S_FIN:  if (hold_done) state_d = S_GAP;
      S_GAP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // out_op is registered, so the word is chosen from the state being entered.
  always_comb begin
    out_op_d = '0;
    unique case (state_d)
      S_HOST:  out_op_d = (state == S_HOST) ? out_op : {4'h0, fifo_mem[rd_ptr]};
      S_EXEC:  out_op_d = {4'h0, (state == S_IDLE) ? winner_id : cur_task, OP_EXECUTE, 4'h0};
      S_FIN:   out_op_d = {4'h0, cur_task, OP_FINISH, 4'h0};
      default: out_op_d = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_op   <= '0;
      cur_task <= '0;
    end else begin
      out_op <= out_op_d;
      if (take) cur_task <= winner_id;
    end
  end

  assign busy = (state != S_IDLE);

endmodule
